// File: rtl/if_id_stage.sv
// Fetch stage of the 5-stage MIPS pipeline: PC register, next-PC selection and the
// IF/ID pipeline register, with hazard-unit stall controls and redirect squashing.
module if_id_stage #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          INST_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_load,
  input  logic              IF_ID_load,
  input  logic [1:0]        pc_src,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] if_id_inst,
  output logic [ADDR_W-1:0] if_id_pc4,
  output logic              if_id_valid,
  output logic [15:0]       stall_cnt
);

  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_pc4;
  logic              r_valid;
  logic [15:0]       r_stall_cnt;

  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_redirect;

  assign w_pc_plus4 = r_pc + ADDR_W'(4);
  assign w_redirect = (pc_src != 2'b00);

  always_comb begin
    w_next_pc = w_pc_plus4;
    unique case (pc_src)
      2'b00: w_next_pc = w_pc_plus4;
      2'b01: w_next_pc = branch_target;
      2'b10: w_next_pc = jump_target;
      2'b11: w_next_pc = jr_target;
      default: w_next_pc = w_pc_plus4;
    endcase
  end

  // A stall holds the PC even when a redirect is pending; ID re-presents pc_src later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (pc_load) begin
      r_pc <= w_next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst  <= '0;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (IF_ID_load) begin
      if (w_redirect) begin
        r_inst  <= '0;
        r_pc4   <= w_pc_plus4;
        r_valid <= 1'b0;
      end else begin
        r_inst  <= imem_data;
        r_pc4   <= w_pc_plus4;
        r_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!pc_load && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign if_id_inst  = r_inst;
  assign if_id_pc4   = r_pc4;
  assign if_id_valid = r_valid;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: stimulus pushes the expected post-edge state,
// a monitor pops and compares after every rising edge.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_load;
  logic        IF_ID_load;
  logic [1:0]  pc_src;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] stall;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: what the stage should hold after the last edge.
  logic [31:0] m_pc, m_inst, m_pc4;
  logic        m_valid;
  int          m_stall;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h20080005;
  endfunction

  assign imem_data = imem_f(imem_addr);

  if_id_stage #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .pc_load(pc_load), .IF_ID_load(IF_ID_load),
    .pc_src(pc_src), .branch_target(branch_target), .jump_target(jump_target),
    .jr_target(jr_target), .imem_addr(imem_addr), .imem_data(imem_data), .pc(pc),
    .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_stall = 0;
  endtask

  // Drive one cycle's inputs (at a falling edge), push the expected result, wait one cycle.
  task automatic cycle(input logic pl, input logic il, input logic [1:0] src,
                       input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] jrt);
    exp_t e;
    logic [31:0] tgt;
    pc_load = pl; IF_ID_load = il; pc_src = src;
    branch_target = bt; jump_target = jt; jr_target = jrt;
    case (src)
      2'd0: tgt = m_pc + 32'd4;
      2'd1: tgt = bt;
      2'd2: tgt = jt;
      default: tgt = jrt;
    endcase
    if (il) begin
      m_pc4   = m_pc + 32'd4;
      m_valid = (src == 2'd0);
      m_inst  = (src == 2'd0) ? imem_f(m_pc) : 32'h0;
    end
    if (pl) m_pc = tgt;
    else if (m_stall < 65535) m_stall = m_stall + 1;
    e.pc = m_pc; e.inst = m_inst; e.pc4 = m_pc4; e.valid = m_valid; e.stall = 16'(m_stall);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 2'd0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_imem_addr"}, imem_addr, 32'h0);
    chk({tag, "_inst"}, if_id_inst, 32'h0);
    chk({tag, "_pc4"}, if_id_pc4, 32'h0);
    chk({tag, "_valid"}, {31'h0, if_id_valid}, 32'h0);
    chk({tag, "_stall"}, {16'h0, stall_cnt}, 32'h0);
  endtask

  // Monitor: after each rising edge, compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", pc, e.pc);
        chk("imem_addr", imem_addr, e.pc);
        chk("if_id_inst", if_id_inst, e.inst);
        chk("if_id_pc4", if_id_pc4, e.pc4);
        chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, e.valid});
        chk("stall_cnt", {16'h0, stall_cnt}, {16'h0, e.stall});
      end
    end
  end

  initial begin
    rst_n = 1'b0; pc_load = 1'b1; IF_ID_load = 1'b1; pc_src = 2'd0;
    branch_target = '0; jump_target = '0; jr_target = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Sequential fetch up to 0x10, then a two-cycle full stall and resume.
    seq(4);
    cycle(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    cycle(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    seq(2);
    // Taken branch, then the target is fetched.
    cycle(1'b1, 1'b1, 2'd1, 32'h40, 32'h0, 32'h0);
    seq(2);
    // Stall with a pending jump, then the jump on the first unstalled cycle.
    cycle(1'b0, 1'b0, 2'd2, 32'h0, 32'h100, 32'h0);
    cycle(1'b1, 1'b1, 2'd2, 32'h0, 32'h100, 32'h0);
    seq(1);
    // Jump-register, then wrap from the top of the address space.
    cycle(1'b1, 1'b1, 2'd3, 32'h0, 32'h0, 32'h2000);
    cycle(1'b1, 1'b1, 2'd2, 32'h0, 32'hFFFF_FFFC, 32'h0);
    seq(2);
    // Independent pc_load / IF_ID_load combinations.
    cycle(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    cycle(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 32'h0);
    cycle(1'b0, 1'b1, 2'd1, 32'h500, 32'h0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic pl, il;
      logic [1:0] src;
      pl  = ($urandom_range(0, 3) != 0);
      il  = ($urandom_range(0, 3) != 0);
      src = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      cycle(pl, il, src, $urandom, $urandom & 32'hFFFF_FFFC, $urandom);
    end

    // Long stall to drive stall_cnt into saturation.
    for (int i = 0; i < 65540; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 2'd0, 32'h0, 32'h0, 32'h0);

    // Asynchronous reset pulsed between edges, mid-stall.
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    seq(3);

    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
